// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: request/ack transactions, watchdog timeout and HALT dump.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject odd-address accesses without a memory request.
module mem_access_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        e_mem,
  input  logic        wr_mem,
  input  logic        cd,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        stall,
  output logic [15:0] rdata,
  output logic        err,
  output logic        halted,
  output logic        mem_req,
  output logic        mem_wr,
  output logic        mem_dump,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUSY,
    S_DUMP,
    S_RESP,
    S_HALT
  } state_t;

  // The counter is cleared on accept, so the last allowed BUSY cycle sees TIMEOUT-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        halted_q, halted_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_wr_q, mem_wr_d;
  logic        mem_dump_q, mem_dump_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        start;
  logic        misalign;

  assign start = valid & (e_mem | cd);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = addr[0];
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      rdata_q     <= 16'd0;
      err_q       <= 1'b0;
      halted_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_dump_q  <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      halted_q    <= halted_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_dump_q  <= mem_dump_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    halted_d    = halted_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_dump_d  = mem_dump_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    stall       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          stall = 1'b1;
          // HALT decodes with e_mem also set, so cd must be tested first.
          if (cd) begin
            state_d    = S_DUMP;
            mem_dump_d = 1'b1;
          end else begin
            mem_addr_d  = addr;
            mem_wdata_d = wdata;
            mem_wr_d    = wr_mem;
            cnt_d       = 8'd0;
            if (misalign) begin
              state_d = S_RESP;
              rdata_d = 16'd0;
              err_d   = 1'b1;
            end else begin
              state_d   = S_BUSY;
              mem_req_d = 1'b1;
            end
          end
        end
      end

      S_BUSY: begin
        stall = 1'b1;
        // An ack in the final allowed cycle takes precedence over the timeout.
        if (mem_ack) begin
          if (!mem_wr_q) begin
            rdata_d = mem_rdata;
          end
          state_d   = S_RESP;
          mem_req_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d   = 16'd0;
          err_d     = 1'b1;
          state_d   = S_RESP;
          mem_req_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_DUMP: begin
        stall = 1'b1;
        if (mem_ack) begin
          state_d    = S_HALT;
          mem_dump_d = 1'b0;
          halted_d   = 1'b1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      S_HALT: begin
        stall = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rdata     = rdata_q;
  assign err       = err_q;
  assign halted    = halted_q;
  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_dump  = mem_dump_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, corner sequences and a
// randomized transaction stream checked against a transaction-level reference model.
module tb_mem_access_ctrl;

  localparam int TO = 4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, valid, e_mem, wr_mem, cd;
  logic [15:0] addr, wdata;
  logic        stall;
  logic [15:0] rdata;
  logic        err, halted, mem_req, mem_wr, mem_dump;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [15:0] model_rdata;

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    int          k;
    logic [15:0] rd;
    int          busy;
    logic        e_err;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vecs[8];

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .e_mem     (e_mem),
    .wr_mem    (wr_mem),
    .cd        (cd),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .rdata     (rdata),
    .err       (err),
    .halted    (halted),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_dump  (mem_dump),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Move to 1ns after the next rising edge; the caller then drives inputs and waits #1 to sample.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access: accept cycle, `busy` BUSY cycles (ack driven on the k-th), then the RESP cycle.
  task automatic run_txn(input logic w, input logic [15:0] a, input logic [15:0] d, input int k,
                         input logic [15:0] rd, input int busy, input logic e_err,
                         input logic [15:0] e_rd);
    tick();
    valid = 1'b1; e_mem = 1'b1; cd = 1'b0; wr_mem = w; addr = a; wdata = d;
    mem_ack = 1'b0; mem_rdata = 16'($urandom);
    #1;
    chk("accept_stall", 16'(stall), 16'd1);
    chk("accept_req", 16'(mem_req), 16'd0);
    chk("accept_err", 16'(err), 16'd0);
    for (int i = 1; i <= busy; i++) begin
      tick();
      mem_ack   = (i == k);
      mem_rdata = (i == k) ? rd : 16'($urandom);
      #1;
      chk("busy_stall", 16'(stall), 16'd1);
      chk("busy_req", 16'(mem_req), 16'd1);
      chk("busy_addr", mem_addr, a);
      chk("busy_wr", 16'(mem_wr), 16'(w));
      if (w) chk("busy_wdata", mem_wdata, d);
    end
    tick();
    mem_ack = 1'b0;
    #1;
    chk("resp_stall", 16'(stall), 16'd0);
    chk("resp_req", 16'(mem_req), 16'd0);
    chk("resp_err", 16'(err), 16'(e_err));
    chk("resp_rdata", rdata, e_rd);
  endtask

  // Idle cycle with a stray ack that must be ignored.
  task automatic gap(input logic [15:0] e_rd);
    tick();
    valid = 1'b0; e_mem = 1'($urandom); cd = 1'b0;
    mem_ack = 1'($urandom); mem_rdata = 16'($urandom);
    #1;
    chk("gap_stall", 16'(stall), 16'd0);
    chk("gap_req", 16'(mem_req), 16'd0);
    chk("gap_err", 16'(err), 16'd0);
    chk("gap_rdata", rdata, e_rd);
  endtask

  initial begin
    logic        w, mis, tmo;
    logic [15:0] a, d, rd;
    int          k, busy;

    rst = 1'b1; valid = 1'b0; e_mem = 1'b0; wr_mem = 1'b0; cd = 1'b0;
    addr = 16'd0; wdata = 16'd0; mem_ack = 1'b0; mem_rdata = 16'd0;
    model_rdata = 16'd0;

    vecs[0] = '{1'b0, 16'h0010, 16'h0000, 3, 16'hBEEF, 3, 1'b0, 16'hBEEF};
    vecs[1] = '{1'b1, 16'h0020, 16'h1234, 1, 16'h9999, 1, 1'b0, 16'hBEEF};
    vecs[2] = '{1'b0, 16'h0030, 16'h0000, 4, 16'h5A5A, 4, 1'b0, 16'h5A5A};
    vecs[3] = '{1'b0, 16'h0032, 16'h0000, 9, 16'h7777, 4, 1'b1, 16'h0000};
    vecs[4] = '{1'b0, 16'h0034, 16'h0000, 1, 16'h0001, 1, 1'b0, 16'h0001};
    vecs[5] = '{1'b1, 16'h0036, 16'hCAFE, 2, 16'h4444, 2, 1'b0, 16'h0001};
    vecs[6] = '{1'b1, 16'h0038, 16'hF00D, 9, 16'h4444, 4, 1'b1, 16'h0000};
    vecs[7] = '{1'b0, 16'hFFFE, 16'h0000, 2, 16'hA5A5, 2, 1'b0, 16'hA5A5};

    repeat (2) tick();
    #1;
    chk("rst_stall", 16'(stall), 16'd0);
    chk("rst_rdata", rdata, 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);
    chk("rst_req", 16'(mem_req), 16'd0);
    chk("rst_wr", 16'(mem_wr), 16'd0);
    chk("rst_dump", 16'(mem_dump), 16'd0);
    chk("rst_addr", mem_addr, 16'd0);
    chk("rst_wdata", mem_wdata, 16'd0);
    rst = 1'b0;

    // Directed vectors: the first two run back-to-back, the rest separated by idle cycles.
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].k, vecs[i].rd,
              vecs[i].busy, vecs[i].e_err, vecs[i].e_rdata);
      if (i >= 1) gap(vecs[i].e_rdata);
    end
    model_rdata = 16'hA5A5;

    // Misaligned load.
    if (ALIGN) begin
      run_txn(1'b0, 16'h0011, 16'h0000, 3, 16'h7777, 0, 1'b1, 16'h0000);
      model_rdata = 16'h0000;
    end else begin
      run_txn(1'b0, 16'h0011, 16'h0000, 3, 16'h7777, 3, 1'b0, 16'h7777);
      model_rdata = 16'h7777;
    end
    gap(model_rdata);

    // Reset asserted on the second BUSY cycle; a later ack must be ignored.
    tick();
    valid = 1'b1; e_mem = 1'b1; wr_mem = 1'b0; cd = 1'b0; addr = 16'h0040; mem_ack = 1'b0;
    #1; chk("mid_accept_stall", 16'(stall), 16'd1);
    tick(); #1; chk("mid_busy1_req", 16'(mem_req), 16'd1);
    tick(); rst = 1'b1; valid = 1'b0; #1; chk("mid_busy2_req", 16'(mem_req), 16'd1);
    tick(); rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hDEAD; #1;
    chk("mid_rst_req", 16'(mem_req), 16'd0);
    chk("mid_rst_stall", 16'(stall), 16'd0);
    chk("mid_rst_rdata", rdata, 16'd0);
    tick(); mem_ack = 1'b0; #1;
    chk("mid_late_ack_req", 16'(mem_req), 16'd0);
    chk("mid_late_ack_stall", 16'(stall), 16'd0);
    chk("mid_late_ack_rdata", rdata, 16'd0);
    chk("mid_late_ack_err", 16'(err), 16'd0);
    model_rdata = 16'd0;

    // Randomized transactions against the transaction-level model.
    for (int n = 0; n < 60; n++) begin
      w  = 1'($urandom);
      a  = 16'($urandom);
      d  = 16'($urandom);
      rd = 16'($urandom);
      k  = int'($urandom_range(1, 6));
      mis = ALIGN && a[0];
      tmo = !mis && (k > TO);
      if (mis) busy = 0;
      else if (tmo) busy = TO;
      else busy = k;
      if (mis || tmo) model_rdata = 16'd0;
      else if (!w) model_rdata = rd;
      run_txn(w, a, d, k, rd, busy, mis || tmo, model_rdata);
      if ($urandom_range(0, 1) == 1) gap(model_rdata);
    end

    // HALT: dump acked on its second cycle, then terminal until reset.
    tick();
    valid = 1'b1; e_mem = 1'b1; cd = 1'b1; wr_mem = 1'b0; mem_ack = 1'b0;
    #1;
    chk("halt_accept_stall", 16'(stall), 16'd1);
    chk("halt_accept_dump", 16'(mem_dump), 16'd0);
    tick(); #1;
    chk("dump1_dump", 16'(mem_dump), 16'd1);
    chk("dump1_req", 16'(mem_req), 16'd0);
    chk("dump1_stall", 16'(stall), 16'd1);
    tick(); mem_ack = 1'b1; #1;
    chk("dump2_dump", 16'(mem_dump), 16'd1);
    chk("dump2_req", 16'(mem_req), 16'd0);
    chk("dump2_stall", 16'(stall), 16'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      mem_ack = 1'($urandom); valid = 1'($urandom); e_mem = 1'($urandom); cd = 1'($urandom);
      #1;
      chk("halt_halted", 16'(halted), 16'd1);
      chk("halt_stall", 16'(stall), 16'd1);
      chk("halt_dump", 16'(mem_dump), 16'd0);
      chk("halt_req", 16'(mem_req), 16'd0);
    end
    tick(); rst = 1'b1; valid = 1'b0; mem_ack = 1'b0; #1;
    tick(); rst = 1'b0; #1;
    chk("post_halt_halted", 16'(halted), 16'd0);
    chk("post_halt_stall", 16'(stall), 16'd0);
    chk("post_halt_rdata", rdata, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller for the 16-bit pipeline. It consumes the decoded `e_mem` / `wr_mem` / `cd` controls plus the effective address and store data, and runs a request/acknowledge transaction against the variable-latency data memory. It stalls the pipeline until the access completes and returns load data. It also enforces a watchdog timeout and sequences the HALT dump into a permanent halted state.

## Interface
- `TIMEOUT`, default 255: BUSY cycles without `mem_ack` before abort; internal counter is 8 bits, legal range 1..255.

- `clk`  in  1  rising-edge clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `valid`  in  1  MEM-stage instruction valid.
- `e_mem`  in  1  access enable from decode.
- `wr_mem`  in  1  1 = store, 0 = load.
- `cd`  in  1  create-dump (HALT).
- `addr`  in  16  effective address.
- `wdata`  in  16  store data.
- `stall`  out  1  hold pipeline (combinational).
- `rdata`  out  16  load data (registered).
- `err`  out  1  one-cycle error pulse (registered).
- `halted`  out  1  sticky halt flag.
- `mem_req`  out  1  memory request.
- `mem_wr`  out  1  request is a write.
- `mem_dump`  out  1  dump request.
- `mem_addr`  out  16  latched address.
- `mem_wdata`  out  16  latched store data.
- `mem_ack`  in  1  memory completion, single cycle.
- `mem_rdata`  in  16  read data, valid with `mem_ack`.

## Operation

**States**
- IDLE, BUSY, DUMP, RESP, HALT.

**Start condition**
- start = `valid & (e_mem | cd)` in IDLE.
- `cd` has priority over `e_mem`, because HALT decodes with both set.

**IDLE**
- start with `cd`: go to DUMP.
- start without `cd`: latch `addr` / `wdata` / `wr_mem` into `mem_*`, clear the counter, go to BUSY.
- Otherwise remain in IDLE.

**BUSY**
- `mem_req`=1, and `mem_addr` / `mem_wdata` / `mem_wr` are held stable.
- On `mem_ack`: for a load, `rdata` <= `mem_rdata`; go to RESP.
- Counter increments each BUSY cycle without ack.
- When the counter reaches `TIMEOUT`: `rdata` <= 0, set the error flag, go to RESP.

**RESP**
- Lasts exactly one cycle; `stall`=0.
- `err`=1 only if this cycle follows a timeout or an alignment fault.
- `valid` is ignored, so the same instruction never restarts.
- Always returns to IDLE.

**DUMP**
- `mem_dump`=1 until `mem_ack`, then go to HALT. No timeout applies in DUMP.

**HALT**
- `halted`=1, `stall`=1; terminal until `rst`.

**Outputs**
- `stall` = (IDLE & start) | BUSY | DUMP | HALT.
- For stores, `rdata` retains its previous value.

**Boundary conditions**
- `mem_ack` outside BUSY/DUMP is ignored.
- Ack in the same cycle the counter reaches `TIMEOUT`: the ack wins and no error is raised.
- `rst` in any state: next state IDLE, and every output returns to its reset value at that edge.

**Reset values**
- state=IDLE.
- `stall` is combinational; it is 0 while `rst` is held, provided no start is present.
- `rdata`=0, `err`=0, `halted`=0.
- `mem_req`=0, `mem_wr`=0, `mem_dump`=0.
- `mem_addr`=0, `mem_wdata`=0, counter=0.

## Timing
- Accept at cycle T (`stall`=1).
- `mem_req` is high from T+1.
- Ack at T+k (k≥1).
- RESP at T+k+1 with `rdata` valid and `stall`=0.
- The pipeline advances at the end of T+k+1.
- Minimum occupancy is 3 cycles; a zero-latency ack in the accept cycle is impossible.
- Timeout: RESP at T+`TIMEOUT`+1, with `mem_req` low from that cycle.
- Back-to-back accesses: the next accept is at T+k+2.
- All outputs except `stall` are registered.

## Configuration
- Macro: `MEM_ALIGN_CHECK_EN`.
- Defined:
  - An access (not a dump) accepted with `addr[0]`=1 never raises `mem_req`.
  - It goes IDLE→RESP directly, so RESP is at T+1 with `err`=1 and `rdata`=0.
- Undefined:
  - No check is made; `addr[0]` is passed through to `mem_addr` unchanged.

## Test plan
- **Load, ack latency 3:** `valid`=1, `e_mem`=1, `wr_mem`=0, `addr`=0x0010; memory acks 3 cycles after `mem_req` with 0xBEEF. Required:
  - `stall` is high for 4 cycles.
  - RESP `rdata`=0xBEEF, `err`=0.
  - `mem_addr`=0x0010 is stable throughout BUSY.
- **Store, ack latency 1:** `wr_mem`=1, `addr`=0x0020, `wdata`=0x1234. Required:
  - `mem_wr`=1, `mem_wdata`=0x1234.
  - `rdata` is unchanged; occupancy is 3 cycles.
- **Timeout:** `TIMEOUT`=4, memory never acks. Required:
  - `mem_req` is high for 4 cycles, then drops.
  - RESP has `err`=1, `rdata`=0; the next cycle is IDLE.
  - Also check: ack on the 4th BUSY cycle gives `err`=0.
- **HALT:** `valid`=1, `e_mem`=1, `cd`=1, dump acks after 2 cycles. Required:
  - `mem_dump` is high 2 cycles and `mem_req` stays 0.
  - `halted`=1 and `stall`=1 permanently, until `rst`.
- **Reset mid-BUSY:** assert `rst` on the 2nd BUSY cycle. Required:
  - At the next edge, `mem_req`=0, `stall`=0 (no start present), state IDLE.
  - A later ack is ignored.
- **Misaligned address, `MEM_ALIGN_CHECK_EN` defined:** load with `addr`=0x0011. Required:
  - `mem_req` is never asserted.
  - T+1 has `err`=1, `stall`=0.
  - Undefined build: the access proceeds with `mem_addr`=0x0011.
